ecpri_tx_sched: RTL and testbench
=================================

# ecpri_tx_sched

Scheduler in front of the eCPRI transmit engine. It queues write-response and read-response jobs from two requesters and arbitrates between them round-robin. It runs one job at a time through the TX engine: resets it, drives `send_write_resp`/`send_read_resp` and `resp_payload_len`, and waits for `cpri_pkt_rdy_flg`. It then hands the finished packet descriptor to the MAC framer and guards the engine with a watchdog.

## Interface
- `LEN_WIDTH`, 8, payload length width in bytes
- `FIFO_DEPTH`, 4, job queue entries; power of two, ≥2
- `TIMEOUT_CYCLES`, 1024, watchdog limit in RUN, ≥2
- `HDR_BYTES`, 16, common header (4) plus remote-memory header (12)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `wr_req`  in  1  write-response job request, level
- `wr_len`  in  LEN_WIDTH  write job length; held with `wr_req`
- `wr_ack`  out  1  one-cycle pulse: write job accepted
- `rd_req`  in  1  read-response job request, level
- `rd_len`  in  LEN_WIDTH  read payload length; held with `rd_req`
- `rd_ack`  out  1  one-cycle pulse: read job accepted
- `tx_rst`  out  1  active-high reset to TX engine
- `send_write_resp`  out  1  held high for whole write job
- `send_read_resp`  out  1  held high for whole read job
- `resp_payload_len`  out  LEN_WIDTH  length of current job
- `cpri_pkt_rdy_flg`  in  1  TX engine packet complete, level
- `pkt_valid`  out  1  packet ready for MAC
- `pkt_len`  out  16  total bytes in packet RAM
- `pkt_is_read`  out  1  1 = read response
- `pkt_ack`  in  1  MAC consumed packet
- `busy`  out  1  FSM not in IDLE, or queue not empty
- `timeout_err`  out  1  sticky watchdog flag
- `err_clr`  in  1  clears `timeout_err`

## Operation
- Queue: FIFO of {type, len}, pointers one bit wider than log2(FIFO_DEPTH); full/empty by MSB compare. Push and pop in the same cycle are both honoured.
- Accept: requests are sampled at each edge when the queue is not full. If only one requester is active it wins. If both are active, round-robin decides: pointer `last` resets to read, so write wins the first tie. Winner gets its ack and its entry is pushed. At most one push per cycle.
- Requesters drop `req` or present the next job in the cycle after ack. An unacked `req` must stay stable.
- FSM states:
  - IDLE: if queue not empty, pop into `cur_type`/`cur_len` → RST_ENG.
  - RST_ENG: `tx_rst`=1 for exactly one cycle → RUN.
  - RUN: `send_*` matching `cur_type` = 1 and `resp_payload_len` = `cur_len`. On `cpri_pkt_rdy_flg` → HANDOFF. On watchdog expiry → ABORT.
  - HANDOFF: `send_*` = 0, `pkt_valid` = 1, `pkt_len` = HDR_BYTES + (read ? cur_len : 0), zero-extended to 16 bits. Hold until `pkt_ack` → IDLE.
  - ABORT: `tx_rst`=1 for one cycle, set `timeout_err`, discard job → IDLE.
- Exactly one of `send_write_resp`/`send_read_resp` is high, and only in RUN.
- `timeout_err` clears on `err_clr`. If set and clear occur in the same cycle, set wins.

## Timing
- Reset: all outputs 0, queue empty, FSM IDLE, `last`=read, watchdog 0. Reset mid-job drops every job with no handoff.
- `wr_ack`/`rd_ack` are registered: high in the cycle after the sampling edge E0. The entry is poppable at E1.
- Idle-to-start: pop at E1, `tx_rst` high E1–E2, `send_*` high from E2.
- Watchdog: counts cycles in RUN starting at 0. Expiry occurs when count reaches TIMEOUT_CYCLES−1 with no `cpri_pkt_rdy_flg`. If `cpri_pkt_rdy_flg` arrives in the expiry cycle, completion wins.
- `pkt_valid` falls the cycle after `pkt_ack`. IDLE may pop the next job in that same cycle. Back-to-back job spacing is therefore ≥3 cycles plus engine time.
- `pkt_ack` outside HANDOFF is ignored.

## Configuration
- `ECPRI_TX_SCHED_TIMEOUT_EN` defined: watchdog and ABORT state compiled in, as described above.
- Not defined: no watchdog counter; RUN waits indefinitely for `cpri_pkt_rdy_flg`; `timeout_err` tied 0; `err_clr` ignored.

## Test plan
- Single write: `wr_req`, `wr_len`=8 → `wr_ack` 1 cycle later. `tx_rst` pulses, then `send_write_resp`=1 with `resp_payload_len`=8. Engine flag asserted → `pkt_valid`, `pkt_len`=16, `pkt_is_read`=0.
- Single read: `rd_len`=32 → `send_read_resp`, then `pkt_len`=48, `pkt_is_read`=1. `pkt_ack` → `pkt_valid`=0 next cycle, `busy`=0.
- Contention: `wr_req` and `rd_req` held together for 4 grants → ack order wr, rd, wr, rd. Queue full (FIFO_DEPTH=4, engine stalled) → no ack until a pop.
- Watchdog (macro on, TIMEOUT_CYCLES=16): engine flag never asserted → ABORT after 16 RUN cycles, one `tx_rst` pulse, `timeout_err`=1, next job starts. `err_clr` → 0.
- Reset mid-RUN: `reset_n` low for 1 cycle during a read job → all outputs 0, queue empty, no `pkt_valid`.
- Macro off: flag withheld for 5000 cycles → `send_read_resp` stays 1, `timeout_err`=0.

Source files
------------

// File: rtl/ecpri_tx_sched_if.sv
// rtl/ecpri_tx_sched_if.sv - requester, TX engine and MAC handshake bundle for ecpri_tx_sched
interface ecpri_tx_sched_if #(
  parameter int LEN_WIDTH = 8
);
  logic                 wr_req;
  logic [LEN_WIDTH-1:0] wr_len;
  logic                 wr_ack;
  logic                 rd_req;
  logic [LEN_WIDTH-1:0] rd_len;
  logic                 rd_ack;
  logic                 tx_rst;
  logic                 send_write_resp;
  logic                 send_read_resp;
  logic [LEN_WIDTH-1:0] resp_payload_len;
  logic                 cpri_pkt_rdy_flg;
  logic                 pkt_valid;
  logic [15:0]          pkt_len;
  logic                 pkt_is_read;
  logic                 pkt_ack;
  logic                 busy;
  logic                 timeout_err;
  logic                 err_clr;

  modport master (
    output wr_req, wr_len, rd_req, rd_len, cpri_pkt_rdy_flg, pkt_ack, err_clr,
    input  wr_ack, rd_ack, tx_rst, send_write_resp, send_read_resp, resp_payload_len,
    input  pkt_valid, pkt_len, pkt_is_read, busy, timeout_err
  );

  modport slave (
    input  wr_req, wr_len, rd_req, rd_len, cpri_pkt_rdy_flg, pkt_ack, err_clr,
    output wr_ack, rd_ack, tx_rst, send_write_resp, send_read_resp, resp_payload_len,
    output pkt_valid, pkt_len, pkt_is_read, busy, timeout_err
  );
endinterface

// File: rtl/ecpri_tx_sched.sv
// rtl/ecpri_tx_sched.sv - round-robin job scheduler for the eCPRI TX engine
// Watchdog and ABORT path are compiled in only when ECPRI_TX_SCHED_TIMEOUT_EN is defined.
module ecpri_tx_sched #(
  parameter int LEN_WIDTH      = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int HDR_BYTES      = 16
) (
  input logic             clk,
  input logic             reset_n,
  ecpri_tx_sched_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic TYPE_WR = 1'b0;
  localparam logic TYPE_RD = 1'b1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RST_ENG = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_HANDOFF = 3'd3;
  localparam logic [2:0] S_ABORT   = 3'd4;

  logic [2:0]           state, state_nxt;
  logic [LEN_WIDTH:0]   fifo_mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 full, empty, push, pop;
  logic                 grant_wr, grant_rd, last;
  logic [LEN_WIDTH:0]   push_data;
  logic                 cur_type;
  logic [LEN_WIDTH-1:0] cur_len;
  logic                 wr_ack_q, rd_ack_q;
  logic                 wd_expire;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // On a tie the requester that was not granted last time wins.
  assign grant_wr  = !full && bus.wr_req && (!bus.rd_req || last == TYPE_RD);
  assign grant_rd  = !full && bus.rd_req && (!bus.wr_req || last == TYPE_WR);
  assign push      = grant_wr || grant_rd;
  assign push_data = grant_wr ? {TYPE_WR, bus.wr_len} : {TYPE_RD, bus.rd_len};
  assign pop       = (state == S_IDLE) && !empty;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last     <= TYPE_RD;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
        last   <= grant_wr ? TYPE_WR : TYPE_RD;
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      wr_ack_q <= grant_wr;
      rd_ack_q <= grant_rd;
    end
  end

`ifdef ECPRI_TX_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  // Completion in the expiry cycle takes priority over the abort.
  assign wd_expire = (state == S_RUN) && !bus.cpri_pkt_rdy_flg &&
                     (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt <= (state == S_RUN) ? wd_cnt + WD_W'(1) : '0;
      if (wd_expire)        timeout_q <= 1'b1;
      else if (bus.err_clr) timeout_q <= 1'b0;
    end
  end

  assign bus.timeout_err = timeout_q;
`else
  logic unused_wd;
  assign unused_wd       = ^{bus.err_clr, 1'(TIMEOUT_CYCLES)};
  assign wd_expire       = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (!empty) state_nxt = S_RST_ENG;
      S_RST_ENG: state_nxt = S_RUN;
      S_RUN: begin
        if (bus.cpri_pkt_rdy_flg) state_nxt = S_HANDOFF;
        else if (wd_expire)       state_nxt = S_ABORT;
      end
      S_HANDOFF: if (bus.pkt_ack) state_nxt = S_IDLE;
      S_ABORT:   state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cur_type <= TYPE_WR;
      cur_len  <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        cur_type <= fifo_mem[rd_ptr[AW-1:0]][LEN_WIDTH];
        cur_len  <= fifo_mem[rd_ptr[AW-1:0]][LEN_WIDTH-1:0];
      end
    end
  end

  assign bus.wr_ack           = wr_ack_q;
  assign bus.rd_ack           = rd_ack_q;
  assign bus.tx_rst           = (state == S_RST_ENG) || (state == S_ABORT);
  assign bus.send_write_resp  = (state == S_RUN) && (cur_type == TYPE_WR);
  assign bus.send_read_resp   = (state == S_RUN) && (cur_type == TYPE_RD);
  assign bus.resp_payload_len = (state == S_RUN) ? cur_len : '0;
  assign bus.pkt_valid        = (state == S_HANDOFF);
  assign bus.pkt_is_read      = (state == S_HANDOFF) && (cur_type == TYPE_RD);
  // Write responses carry no payload, so only the header lands in packet RAM.
  assign bus.pkt_len          = (state == S_HANDOFF) ?
                                16'(HDR_BYTES) + ((cur_type == TYPE_RD) ? 16'(cur_len) : 16'd0) :
                                16'd0;
  assign bus.busy             = (state != S_IDLE) || !empty;
endmodule

// File: tb/tb_ecpri_tx_sched.sv
// tb/tb_ecpri_tx_sched.sv - directed scoreboard bench for ecpri_tx_sched
module tb_ecpri_tx_sched;
  localparam int LW = 8;

  typedef struct packed {
    logic          is_read;
    logic [LW-1:0] len;
  } job_t;

  logic   clk = 1'b0;
  logic   reset_n = 1'b0;
  int     n_checks = 0;
  int     n_errors = 0;
  job_t   sb[$];
  logic [LW-1:0] wl [4];
  logic [LW-1:0] rl [3];

  ecpri_tx_sched_if #(.LEN_WIDTH(LW)) bus ();

  ecpri_tx_sched #(
    .LEN_WIDTH(LW), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16), .HDR_BYTES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic job_t mk(input logic r, input logic [LW-1:0] l);
    job_t j;
    j.is_read = r;
    j.len     = l;
    return j;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_wr_ack"}, 32'(bus.wr_ack), 32'd0);
    check({tag, "_rd_ack"}, 32'(bus.rd_ack), 32'd0);
    check({tag, "_tx_rst"}, 32'(bus.tx_rst), 32'd0);
    check({tag, "_send"}, 32'({bus.send_write_resp, bus.send_read_resp}), 32'd0);
    check({tag, "_resp_len"}, 32'(bus.resp_payload_len), 32'd0);
    check({tag, "_pkt_valid"}, 32'(bus.pkt_valid), 32'd0);
    check({tag, "_pkt_len"}, 32'(bus.pkt_len), 32'd0);
    check({tag, "_pkt_is_read"}, 32'(bus.pkt_is_read), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
  endtask

  // Runs the next started job through the engine and compares it with the scoreboard head.
  task automatic do_job(input int hold);
    job_t j;
    int   n;
    int   held;
    n = 0;
    while (!(bus.send_write_resp || bus.send_read_resp) && n < 200) begin
      tick();
      n++;
    end
    check("job_start_bound", 32'(n < 200), 32'd1);
    if (sb.size() > 0) j = sb.pop_front();
    else j = mk(1'bx, 'x);
    check("send_write_resp", 32'(bus.send_write_resp), 32'(!j.is_read));
    check("send_read_resp", 32'(bus.send_read_resp), 32'(j.is_read));
    check("resp_payload_len", 32'(bus.resp_payload_len), 32'(j.len));
    held = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (bus.send_write_resp === !j.is_read && bus.send_read_resp === j.is_read &&
          bus.resp_payload_len === j.len && bus.tx_rst === 1'b0)
        held++;
    end
    check("send_held", 32'(held), 32'(hold));
    bus.cpri_pkt_rdy_flg = 1'b1;
    tick();
    bus.cpri_pkt_rdy_flg = 1'b0;
    check("pkt_valid", 32'(bus.pkt_valid), 32'd1);
    check("pkt_len", 32'(bus.pkt_len), 32'd16 + (j.is_read ? 32'(j.len) : 32'd0));
    check("pkt_is_read", 32'(bus.pkt_is_read), 32'(j.is_read));
    check("send_off_handoff", 32'({bus.send_write_resp, bus.send_read_resp}), 32'd0);
    tick();
    check("pkt_valid_hold", 32'(bus.pkt_valid), 32'd1);
    bus.pkt_ack = 1'b1;
    tick();
    bus.pkt_ack = 1'b0;
    check("pkt_valid_fall", 32'(bus.pkt_valid), 32'd0);
  endtask

  initial begin
    int  waited;
    int  acks;
    int  bad;
    int  wi;
    int  ri;
    logic exp_wr;

    bus.wr_req = 1'b0;
    bus.wr_len = '0;
    bus.rd_req = 1'b0;
    bus.rd_len = '0;
    bus.cpri_pkt_rdy_flg = 1'b0;
    bus.pkt_ack = 1'b0;
    bus.err_clr = 1'b0;
    wl = '{8'd3, 8'd7, 8'd11, 8'd15};
    rl = '{8'd5, 8'd9, 8'd13};

    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    reset_n = 1'b1;
    tick();

    // Single write, with exact start-up latency
    sb.push_back(mk(1'b0, 8'd8));
    bus.wr_req = 1'b1;
    bus.wr_len = 8'd8;
    tick();
    check("wr_ack_e0", 32'(bus.wr_ack), 32'd1);
    check("rd_ack_e0", 32'(bus.rd_ack), 32'd0);
    check("tx_rst_e0", 32'(bus.tx_rst), 32'd0);
    bus.wr_req = 1'b0;
    tick();
    check("wr_ack_pulse", 32'(bus.wr_ack), 32'd0);
    check("tx_rst_e1", 32'(bus.tx_rst), 32'd1);
    check("send_e1", 32'(bus.send_write_resp), 32'd0);
    tick();
    check("tx_rst_e2", 32'(bus.tx_rst), 32'd0);
    do_job(0);

    // Single read
    sb.push_back(mk(1'b1, 8'd32));
    bus.rd_req = 1'b1;
    bus.rd_len = 8'd32;
    tick();
    check("rd_ack_single", 32'(bus.rd_ack), 32'd1);
    bus.rd_req = 1'b0;
    do_job(2);
    check("busy_after_read", 32'(bus.busy), 32'd0);

    // Contention: alternating grants, then queue full while the engine stalls
    for (int k = 0; k < 5; k++)
      sb.push_back((k % 2 == 0) ? mk(1'b0, wl[k/2]) : mk(1'b1, rl[k/2]));
    wi = 0;
    ri = 0;
    bus.wr_req = 1'b1;
    bus.wr_len = wl[0];
    bus.rd_req = 1'b1;
    bus.rd_len = rl[0];
    for (int k = 0; k < 5; k++) begin
      tick();
      exp_wr = (k % 2 == 0);
      check("rr_wr_ack", 32'(bus.wr_ack), 32'(exp_wr));
      check("rr_rd_ack", 32'(bus.rd_ack), 32'(!exp_wr));
      if (exp_wr) begin
        wi++;
        bus.wr_len = wl[wi];
      end else begin
        ri++;
        bus.rd_len = rl[ri];
      end
    end
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.wr_ack || bus.rd_ack) acks++;
    end
    check("full_no_ack", 32'(acks), 32'd0);
    check("full_busy", 32'(bus.busy), 32'd1);
    sb.push_back(mk(1'b1, rl[2]));
    do_job(0);
    waited = 0;
    while (!(bus.wr_ack || bus.rd_ack) && waited < 6) begin
      tick();
      waited++;
    end
    check("ack_after_pop_delay", 32'(waited), 32'd2);
    check("ack_after_pop_rd", 32'(bus.rd_ack), 32'd1);
    check("ack_after_pop_wr", 32'(bus.wr_ack), 32'd0);
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    for (int k = 0; k < 5; k++) do_job(1);
    check("busy_after_drain", 32'(bus.busy), 32'd0);

`ifdef ECPRI_TX_SCHED_TIMEOUT_EN
    // Watchdog: the write job is never completed and gets aborted
    bus.wr_req = 1'b1;
    bus.wr_len = 8'd4;
    tick();
    check("wd_wr_ack", 32'(bus.wr_ack), 32'd1);
    bus.wr_req = 1'b0;
    sb.push_back(mk(1'b1, 8'd12));
    bus.rd_req = 1'b1;
    bus.rd_len = 8'd12;
    tick();
    check("wd_rd_ack", 32'(bus.rd_ack), 32'd1);
    bus.rd_req = 1'b0;
    waited = 0;
    while (!bus.send_write_resp && waited < 20) begin
      tick();
      waited++;
    end
    check("wd_start_bound", 32'(waited < 20), 32'd1);
    waited = 0;
    while (bus.send_write_resp && waited < 100) begin
      tick();
      waited++;
    end
    check("wd_run_cycles", 32'(waited), 32'd16);
    check("wd_abort_tx_rst", 32'(bus.tx_rst), 32'd1);
    check("wd_timeout_set", 32'(bus.timeout_err), 32'd1);
    check("wd_no_pkt", 32'(bus.pkt_valid), 32'd0);
    tick();
    check("wd_tx_rst_pulse", 32'(bus.tx_rst), 32'd0);
    do_job(1);
    check("wd_timeout_sticky", 32'(bus.timeout_err), 32'd1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("wd_err_clr", 32'(bus.timeout_err), 32'd0);
`else
    // No watchdog: a withheld engine flag stalls the job indefinitely
    sb.push_back(mk(1'b1, 8'd20));
    bus.rd_req = 1'b1;
    bus.rd_len = 8'd20;
    tick();
    check("nowd_rd_ack", 32'(bus.rd_ack), 32'd1);
    bus.rd_req = 1'b0;
    bus.err_clr = 1'b1;
    do_job(5000);
    bus.err_clr = 1'b0;
    check("nowd_timeout_err", 32'(bus.timeout_err), 32'd0);
`endif

    // Reset in the middle of a read job with another job queued
    bus.rd_req = 1'b1;
    bus.rd_len = 8'd40;
    tick();
    check("mr_rd_ack", 32'(bus.rd_ack), 32'd1);
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b1;
    bus.wr_len = 8'd2;
    tick();
    check("mr_wr_ack", 32'(bus.wr_ack), 32'd1);
    bus.wr_req = 1'b0;
    waited = 0;
    while (!bus.send_read_resp && waited < 20) begin
      tick();
      waited++;
    end
    check("mr_start_bound", 32'(waited < 20), 32'd1);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check_quiet("midrst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.pkt_valid || bus.send_write_resp || bus.send_read_resp || bus.tx_rst || bus.busy)
        bad++;
    end
    check("midrst_dropped", 32'(bad), 32'd0);

    // Round-robin pointer restarts at read, so write wins the first tie
    sb.push_back(mk(1'b0, 8'd6));
    sb.push_back(mk(1'b1, 8'd10));
    bus.wr_req = 1'b1;
    bus.wr_len = 8'd6;
    bus.rd_req = 1'b1;
    bus.rd_len = 8'd10;
    tick();
    check("post_rst_wr_ack", 32'(bus.wr_ack), 32'd1);
    check("post_rst_rd_ack0", 32'(bus.rd_ack), 32'd0);
    bus.wr_req = 1'b0;
    tick();
    check("post_rst_rd_ack", 32'(bus.rd_ack), 32'd1);
    bus.rd_req = 1'b0;
    do_job(2);
    do_job(2);
    check("final_busy", 32'(bus.busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
